// File: rtl/decode_pkg.sv
// Shared types and helpers for the 3-to-8 decode / strobe path.
// Also used by encoder-side benches that need a reference one-hot.
package decode_pkg;

    localparam int CODE_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_GAP
    } state_e;

    function automatic logic [7:0] onehot8(input logic [CODE_W-1:0] code);
        return 8'b1 << code;
    endfunction

endpackage

// File: rtl/decode38_strobe_if.sv
// Encoded-index handshake: code/idc from the producer, ready back from the decoder.
interface decode38_strobe_if;
    import decode_pkg::*;

    logic [CODE_W-1:0] code;
    logic              idc;
    logic              ready;

    modport master (output code, output idc, input ready);
    modport slave  (input code, input idc, output ready);

endinterface

// File: rtl/decode38_strobe.sv
// Registered 3-to-8 decoder: each accepted code becomes a HOLD-cycle one-hot
// strobe followed by GAP quiet cycles, with one pending slot for back-to-back codes.
module decode38_strobe
    import decode_pkg::*;
#(
    parameter int OUT_W = 8,
    parameter int HOLD  = 4,
    parameter int GAP   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    decode38_strobe_if.slave  hs,
    output logic [OUT_W-1:0]  y,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_MAX = (HOLD > GAP) ? HOLD : GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   y_q, y_d;
    logic               pend_v_q, pend_v_d;
    logic [CODE_W-1:0]  pend_code_q, pend_code_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic ready;
    logic accept;
    logic code_ok;
    logic end_of_gap;

    function automatic logic [OUT_W-1:0] strobe_of(input logic [CODE_W-1:0] c);
        logic [7:0] oh;
        oh = onehot8(c);
        return oh[OUT_W-1:0];
    endfunction

    // The pending slot is the only thing that can block a new code.
    assign ready   = en && ((state_q == ST_IDLE) || !pend_v_q);
    assign accept  = hs.idc && ready;
    assign code_ok = int'(hs.code) < OUT_W;

    // Point where the next strobe may start: end of the gap, or end of the
    // hold phase when there is no gap at all.
    assign end_of_gap = (cnt_q == '0) &&
                        ((state_q == ST_GAP) || ((state_q == ST_ACTIVE) && (GAP == 0)));

    always_comb begin
        // NOTE: every _d gets its hold value first, so no branch can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        y_d         = y_q;
        pend_v_d    = pend_v_q;
        pend_code_d = pend_code_q;
        err_d       = 1'b0;

        if (!en) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            y_d      = '0;
            pend_v_d = 1'b0;
        end else begin
            err_d = accept && !code_ok;

            unique case (state_q)
                ST_IDLE: begin
                    if (accept && code_ok) begin
                        state_d = ST_ACTIVE;
                        y_d     = strobe_of(hs.code);
                        cnt_d   = HOLD_LD;
                    end
                end
                ST_ACTIVE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else if (GAP > 0) begin
                        state_d = ST_GAP;
                        y_d     = '0;
                        cnt_d   = GAP_LD;
                    end
                end
                ST_GAP: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (end_of_gap) begin
                if (pend_v_q) begin
                    state_d  = ST_ACTIVE;
                    y_d      = strobe_of(pend_code_q);
                    cnt_d    = HOLD_LD;
                    pend_v_d = 1'b0;
                end else if (accept && code_ok) begin
                    state_d = ST_ACTIVE;
                    y_d     = strobe_of(hs.code);
                    cnt_d   = HOLD_LD;
                end else begin
                    state_d = ST_IDLE;
                    y_d     = '0;
                    cnt_d   = '0;
                end
            end else if ((state_q != ST_IDLE) && accept && code_ok) begin
                pend_v_d    = 1'b1;
                pend_code_d = hs.code;
            end
        end

        // Registered so done lines up with the last high cycle of y.
        done_d = (state_d == ST_ACTIVE) && (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            y_q         <= '0;
            pend_v_q    <= 1'b0;
            pend_code_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking here so every flop samples the pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            y_q         <= y_d;
            pend_v_q    <= pend_v_d;
            pend_code_q <= pend_code_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign hs.ready = ready;
    assign y        = y_q;
    assign done     = done_q;
    assign err      = err_q;
    assign busy     = (state_q != ST_IDLE) || pend_v_q;

endmodule

// File: tb/tb_decode38_strobe.sv
// Scoreboard bench: a strobe-schedule model predicts each strobe at acceptance,
// a monitor reconstructs strobes from y/done and compares them in order.
module tb_decode38_strobe;
    import decode_pkg::*;

    localparam int HOLD = 4;
    localparam int GAP  = 1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic [7:0] y8;
    logic       busy8, done8, err8;
    logic [5:0] y6;
    logic       busy6, done6, err6;

    decode38_strobe_if hs8 ();
    decode38_strobe_if hs6 ();

    decode38_strobe #(.OUT_W(8), .HOLD(HOLD), .GAP(GAP)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .hs    (hs8.slave),
        .y     (y8),
        .busy  (busy8),
        .done  (done8),
        .err   (err8)
    );

    decode38_strobe #(.OUT_W(6), .HOLD(HOLD), .GAP(GAP)) u_dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .hs    (hs6.slave),
        .y     (y6),
        .busy  (busy6),
        .done  (done6),
        .err   (err6)
    );

    always #5 clk = ~clk;

    // Edge counter: a value sampled between edge n and edge n+1 belongs to index n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at idx %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model: a schedule of strobes ----------------
    typedef struct {
        int         start;
        logic [7:0] oh;
        int         len;
        bit         done_exp;
    } strobe_t;

    strobe_t exp_q[$];
    int next_free  = 0;
    int busy_until = -1;

    function automatic bit model_pending(input int t);
        foreach (exp_q[i]) if (exp_q[i].start > t) return 1'b1;
        return 1'b0;
    endfunction

    // A code accepted at edge e starts as soon as the previous strobe plus gap is over.
    task automatic model_accept(input int e, input logic [2:0] c);
        strobe_t r;
        r.start    = (e > next_free) ? e : next_free;
        r.oh       = '0;
        r.oh[c]    = 1'b1;
        r.len      = HOLD;
        r.done_exp = 1'b1;
        exp_q.push_back(r);
        next_free  = r.start + HOLD + GAP;
        busy_until = next_free - 1;
    endtask

    // Everything is cleared at edge a: unstarted strobes vanish, a running one is cut.
    task automatic model_abort(input int a);
        strobe_t kept[$];
        foreach (exp_q[i]) begin
            strobe_t r;
            r = exp_q[i];
            if (r.start < a) begin
                if (r.start + r.len > a) begin
                    r.len      = a - r.start;
                    r.done_exp = 1'b0;
                end
                kept.push_back(r);
            end
        end
        exp_q      = kept;
        next_free  = a;
        busy_until = a - 1;
    endtask

    // ---------------- monitor ----------------
    bit         in_s = 1'b0;
    int         s_start, s_len, s_done_cnt;
    bit         s_done_last;
    logic [7:0] s_oh;
    bit         err8_seen = 1'b0;

    task automatic finish_strobe();
        strobe_t r;
        if (exp_q.size() == 0) begin
            check("unexpected_strobe", s_oh, 0);
        end else begin
            r = exp_q.pop_front();
            check("strobe_start", s_start, r.start);
            check("strobe_y", s_oh, r.oh);
            check("strobe_len", s_len, r.len);
            check("strobe_done_cnt", s_done_cnt, r.done_exp ? 1 : 0);
            if (r.done_exp) check("strobe_done_last", s_done_last, 1);
        end
    endtask

    always @(negedge clk) begin
        if (err8 === 1'b1) err8_seen = 1'b1;
        if (in_s && (y8 === s_oh)) begin
            s_len++;
            if (done8 === 1'b1) s_done_cnt++;
            s_done_last = (done8 === 1'b1);
        end else begin
            if (in_s) begin
                finish_strobe();
                in_s = 1'b0;
            end
            if ((y8 !== 8'h00) && !$isunknown(y8)) begin
                check("y_onehot", $countones(y8), 1);
                in_s        = 1'b1;
                s_start     = cyc;
                s_oh        = y8;
                s_len       = 1;
                s_done_cnt  = (done8 === 1'b1) ? 1 : 0;
                s_done_last = (done8 === 1'b1);
            end else if (done8 === 1'b1) begin
                check("done_outside_strobe", done8, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic en_v, input logic idc_v, input logic [2:0] code_v);
        int   t;
        logic m_ready;
        @(negedge clk);
        en       = en_v;
        hs8.idc  = idc_v;
        hs8.code = code_v;
        #1;
        t       = cyc;
        m_ready = en_v && !model_pending(t);
        check("ready", hs8.ready, m_ready);
        check("busy", busy8, (t <= busy_until) ? 1 : 0);
        if (!en_v) model_abort(t + 1);
        else if (idc_v && m_ready) model_accept(t + 1, code_v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 3'd0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_y", y8, 0);
        check("rst_done", done8, 0);
        check("rst_busy", busy8, 0);
        model_abort(cyc + 1);
        hs8.idc = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic random_phase(input int n);
        logic       e_v, i_v;
        logic [2:0] c_v;
        for (int i = 0; i < n; i++) begin
            e_v = ($urandom_range(0, 24) != 0);
            i_v = ($urandom_range(0, 2) != 0);
            c_v = 3'($urandom_range(0, 7));
            step(e_v, i_v, c_v);
        end
    endtask

    task automatic out_of_range_phase();
        logic [5:0] exp6;
        exp6    = '0;
        exp6[4] = 1'b1;
        @(negedge clk);
        hs6.code = 3'd6;
        hs6.idc  = 1'b1;
        #1;
        check("dut6_ready", hs6.ready, 1);
        @(negedge clk);
        hs6.idc = 1'b0;
        #1;
        check("dut6_err_pulse", err6, 1);
        check("dut6_y_after_bad", y6, 0);
        check("dut6_busy_after_bad", busy6, 0);
        for (int k = 0; k < HOLD + 1; k++) begin
            @(negedge clk);
            #1;
            check("dut6_err_once", err6, 0);
            check("dut6_quiet_y", y6, 0);
            check("dut6_quiet_done", done6, 0);
        end
        @(negedge clk);
        hs6.code = 3'd4;
        hs6.idc  = 1'b1;
        @(negedge clk);
        hs6.idc = 1'b0;
        #1;
        for (int k = 0; k < HOLD; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            check("dut6_y", y6, exp6);
            check("dut6_done", done6, (k == HOLD - 1) ? 1 : 0);
            check("dut6_err_good", err6, 0);
        end
        @(negedge clk);
        #1;
        check("dut6_y_end", y6, 0);
    endtask

    initial begin
        int guard;
        hs8.code = '0;
        hs8.idc  = 1'b0;
        hs6.code = '0;
        hs6.idc  = 1'b0;
        en       = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_y", y8, 0);
        check("reset_busy", busy8, 0);
        check("reset_done", done8, 0);
        rst_n = 1'b1;

        idle(1);
        // single strobe
        step(1'b1, 1'b1, 3'd5);
        idle(7);
        // back-to-back through the pending slot
        step(1'b1, 1'b1, 3'd2);
        step(1'b1, 1'b0, 3'd0);
        step(1'b1, 1'b1, 3'd7);
        idle(12);
        // new code offered exactly at the end of the gap
        step(1'b1, 1'b1, 3'd3);
        idle(4);
        step(1'b1, 1'b1, 3'd1);
        idle(8);
        // abort with a pending code, then a normal strobe
        step(1'b1, 1'b1, 3'd6);
        step(1'b1, 1'b1, 3'd0);
        step(1'b0, 1'b0, 3'd0);
        step(1'b1, 1'b1, 3'd4);
        idle(8);
        // asynchronous reset in the middle of a strobe
        step(1'b1, 1'b1, 3'd5);
        idle(2);
        async_reset();
        idle(2);

        random_phase(400);

        guard = 0;
        while (((exp_q.size() != 0) || in_s) && (guard < 60)) begin
            step(1'b1, 1'b0, 3'd0);
            guard++;
        end
        check("drain_empty", exp_q.size(), 0);
        check("err8_never", err8_seen, 0);

        out_of_range_phase();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/decode38_strobe.md
Name: decode38_strobe

Overview:
- Registered 3-to-8 decoder with a strobe sequencer; the receive-side counterpart of the 8-to-3 priority encoder.
- Accepts an encoded index plus valid indicator (code/idc, as produced by the encoder) through a valid/ready handshake.
- Drives the matching one-hot output line for a fixed HOLD-cycle strobe, then a GAP-cycle quiet period.
- Provides a one-entry pending buffer so back-to-back codes stream with no bubble beyond GAP.

Parameters:
- OUT_W, 8: number of one-hot output lines (2..8).
- HOLD, 4: cycles y stays high per accepted code (>=1).
- GAP, 1: cycles y is forced 0 between strobes (>=0; 0 = no gap).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  block enable; low = synchronous abort/flush.
- code  input  3  encoded line index.
- idc  input  1  code valid.
- ready  output  1  block can accept code this cycle.
- y  output  OUT_W  registered one-hot strobe.
- busy  output  1  state != IDLE or pending entry valid.
- done  output  1  one-cycle pulse on the last high cycle of each strobe.
- err  output  1  one-cycle pulse when an accepted code is >= OUT_W.

Behaviour:
- Reset (async, rst_n=0): state IDLE, pend_v=0, counter=0, y=0, done=0, err=0; busy=0. ready = en (combinational).
- Accept: idc && ready sampled at a rising edge. ready = en && (state==IDLE || !pend_v).
- FSM states IDLE, ACTIVE, GAP; cnt width = $clog2(max(HOLD,GAP)+1).
- IDLE + accept: next state ACTIVE, y <= 1<<code, cnt <= HOLD-1. y is high from the cycle after acceptance (latency 1).
- ACTIVE, cnt>0: cnt decrements, y holds.
- ACTIVE, cnt==0: done=1 this cycle. Next state:
  - GAP=0: as in the end-of-GAP rule below.
  - GAP>0: GAP, y <= 0, cnt <= GAP-1.
- GAP, cnt>0: cnt decrements, y=0.
- End of GAP (GAP, cnt==0; or ACTIVE end with GAP=0):
  - pend_v=1: load pend_code into ACTIVE, clear pend_v.
  - Else, accept this cycle: bypass the new code straight into ACTIVE.
  - Else: IDLE, y <= 0.
- Accept while ACTIVE/GAP with pend_v=0 and not at end-of-GAP: store into pend_code, set pend_v=1.
- Simultaneous pend-load and new idc: ready is already low (pend_v=1), so the code is not accepted. Upstream holds code/idc.
- Out-of-range code (>= OUT_W):
  - Accepted (handshake completes), err pulses the cycle after acceptance.
  - Not stored in pend, y unchanged, no strobe, no done.
  - With OUT_W=8 this is unreachable.
- en=0 at any edge: next state IDLE, pend_v=0, y=0, cnt=0; no done, no err. ready=0 while en=0.
- done is never asserted outside ACTIVE.
- y is at most one-hot at all times.
- Reset mid-strobe: y drops to 0 immediately (async); nothing resumes after release.

Decomposition:
- Shared package decode_pkg: state enum (IDLE/ACTIVE/GAP) and a CODE_W=3 constant. Also the one-hot helper function onehot8(code), reusable by encoder-side benches.
- No sub-module needed: FSM, counter and pending register fit in one module, ~150 lines.

Test Plan (OUT_W=8, HOLD=4, GAP=1 unless noted; cycle 0 = acceptance edge):
- Reset: rst_n=0 while y=8'h20 -> y=0, done=0, busy=0 immediately. After release with en=1, ready=1.
- Single code=5 at cycle 0 -> y=8'h20 cycles 1-4, done=1 cycle 4, y=0 cycle 5, IDLE/busy=0 cycle 6. ready stays 1 throughout.
- Back-to-back code=2 at cycle 0, code=7 at cycle 2:
  - y=8'h04 cycles 1-4, y=0 cycle 5, y=8'h80 cycles 6-9.
  - ready=0 cycles 3-5, 1 again cycle 6.
  - done at cycles 4 and 9.
- Bypass: code=3 then code=1 presented exactly in cycle 5 (end of GAP, pend empty) -> y=8'h02 from cycle 6, no extra bubble.
- Abort: en=0 in cycle 2 of a code=6 strobe with a pending code=0 -> y=0 and busy=0 from cycle 3, no done. After en=1, the next code strobes normally; code 0 never appears.
- OUT_W=6: code=6 accepted -> err=1 at cycle 1, y stays 0, no done. A following code=4 gives y=6'h10 for 4 cycles.
